// File: rtl/olm_pkg.sv
// Shared constants and FSM state type for the output-layer MAC.
package olm_pkg;
  localparam int DATA_W = 8;
  localparam int N_HID  = 30;
  localparam int N_OUT  = 10;
  localparam int ACC_W  = 24;
  localparam int K_W    = 5;
  localparam int J_W    = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_ARGMAX
  } state_t;
endpackage

// File: rtl/output_layer_mac_sm_mul.sv
// Sign-magnitude weight times unsigned activation, sign-extended to ACC_W.
module sm_mul
  import olm_pkg::*;
(
  input  logic        [DATA_W-1:0] weight,
  input  logic        [DATA_W-1:0] act,
  output logic signed [ACC_W-1:0]  prod
);
  logic [2*DATA_W-2:0] mag_prod;
  logic [ACC_W-1:0]    ext;

  assign mag_prod = {{DATA_W{1'b0}}, weight[DATA_W-2:0]} * {{(DATA_W-1){1'b0}}, act};
  assign ext      = {{(ACC_W-2*DATA_W+1){1'b0}}, mag_prod};
  // 8'h80 has zero magnitude, so negation still yields 0.
  assign prod     = weight[DATA_W-1] ? -$signed(ext) : $signed(ext);
endmodule

// File: rtl/output_layer_mac.sv
// Output layer: ten parallel serial dot products over 30 hidden activations, then argmax.
// Optional OLM_SCORES_EN exposes the final accumulator values as scores_out.
//
//   state    | meaning
//   S_IDLE   | waiting for start; results held
//   S_ACCUM  | one hidden index per cycle into all ten accumulators (k = 0..29)
//   S_ARGMAX | strict signed compare of acc[j] against acc[best] (j = 1..9)
module output_layer_mac
  import olm_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [N_HID*DATA_W-1:0]   h_in,
  input  logic [N_HID*DATA_W-1:0]   wo0,
  input  logic [N_HID*DATA_W-1:0]   wo1,
  input  logic [N_HID*DATA_W-1:0]   wo2,
  input  logic [N_HID*DATA_W-1:0]   wo3,
  input  logic [N_HID*DATA_W-1:0]   wo4,
  input  logic [N_HID*DATA_W-1:0]   wo5,
  input  logic [N_HID*DATA_W-1:0]   wo6,
  input  logic [N_HID*DATA_W-1:0]   wo7,
  input  logic [N_HID*DATA_W-1:0]   wo8,
  input  logic [N_HID*DATA_W-1:0]   wo9,
  output logic                      busy,
  output logic                      done,
  output logic [3:0]                class_out
`ifdef OLM_SCORES_EN
  ,
  output logic [N_OUT*ACC_W-1:0]    scores_out
`endif
);
  state_t state, next_state;

  logic        [N_HID*DATA_W-1:0] wo [N_OUT];
  logic        [N_HID*DATA_W-1:0] h_reg;
  logic        [DATA_W-1:0]       h_byte;
  logic signed [ACC_W-1:0]        acc  [N_OUT];
  logic signed [ACC_W-1:0]        prod [N_OUT];
  logic        [K_W-1:0]          k;
  logic        [J_W-1:0]          j;
  logic        [J_W-1:0]          best;
  logic                           j_wins;
  logic                           k_last;
  logic                           j_last;

  assign wo[0] = wo0;
  assign wo[1] = wo1;
  assign wo[2] = wo2;
  assign wo[3] = wo3;
  assign wo[4] = wo4;
  assign wo[5] = wo5;
  assign wo[6] = wo6;
  assign wo[7] = wo7;
  assign wo[8] = wo8;
  assign wo[9] = wo9;

  assign h_byte = h_reg[DATA_W*k +: DATA_W];
  assign k_last = (k == K_W'(N_HID - 1));
  assign j_last = (j == J_W'(N_OUT - 1));
  assign j_wins = (acc[j] > acc[best]);
  assign busy   = (state != S_IDLE);

  for (genvar i = 0; i < N_OUT; i++) begin : g_mul
    sm_mul u_mul (
      .weight (wo[i][DATA_W*k +: DATA_W]),
      .act    (h_byte),
      .prod   (prod[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (start)  next_state = S_ACCUM;
      S_ACCUM:  if (k_last) next_state = S_ARGMAX;
      S_ARGMAX: if (j_last) next_state = S_IDLE;
      default:              next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_reg     <= '0;
      k         <= '0;
      j         <= '0;
      best      <= '0;
      done      <= 1'b0;
      class_out <= '0;
      for (int i = 0; i < N_OUT; i++) acc[i] <= '0;
`ifdef OLM_SCORES_EN
      scores_out <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            h_reg <= h_in;
            k     <= '0;
            for (int i = 0; i < N_OUT; i++) acc[i] <= '0;
          end
        end
        S_ACCUM: begin
          for (int i = 0; i < N_OUT; i++) acc[i] <= acc[i] + prod[i];
          k <= k + 1'b1;
          if (k_last) begin
            best <= '0;
            j    <= J_W'(1);
          end
        end
        S_ARGMAX: begin
          if (j_wins) best <= j;
          j <= j + 1'b1;
          if (j_last) begin
            class_out <= j_wins ? j : best;
            done      <= 1'b1;
`ifdef OLM_SCORES_EN
            for (int i = 0; i < N_OUT; i++) scores_out[ACC_W*i +: ACC_W] <= acc[i];
`endif
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_output_layer_mac.sv
// Directed self-checking bench for output_layer_mac (scores checked when OLM_SCORES_EN is defined).
module tb_output_layer_mac;
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [239:0] h_in;
  logic [239:0] wo [10];
  logic         busy;
  logic         done;
  logic [3:0]   class_out;
`ifdef OLM_SCORES_EN
  logic [239:0] scores_out;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int pw [10] = '{-25, -4, -30, 11, -2, -6, -19, 0, 30, 3};

  always #5 clk = ~clk;

  output_layer_mac dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .h_in      (h_in),
    .wo0       (wo[0]),
    .wo1       (wo[1]),
    .wo2       (wo[2]),
    .wo3       (wo[3]),
    .wo4       (wo[4]),
    .wo5       (wo[5]),
    .wo6       (wo[6]),
    .wo7       (wo[7]),
    .wo8       (wo[8]),
    .wo9       (wo[9]),
    .busy      (busy),
    .done      (done),
    .class_out (class_out)
`ifdef OLM_SCORES_EN
    ,
    .scores_out(scores_out)
`endif
  );

  function automatic logic [7:0] to_sm(input int v);
    logic [6:0] mag;
    mag = (v < 0) ? 7'(-v) : 7'(v);
    return {(v < 0), mag};
  endfunction

  function automatic int score(input int i);
`ifdef OLM_SCORES_EN
    return int'($signed(scores_out[24*i +: 24]));
`else
    return i - i;
`endif
  endfunction

  task automatic set_prod_weights();
    for (int i = 0; i < 10; i++)
      for (int k = 0; k < 30; k++)
        wo[i][8*k +: 8] = (k == 0) ? to_sm(pw[i]) : 8'(i * 7 + k * 13);
  endtask

  task automatic run_op(output int lat);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; h_in = '0;
    for (int i = 0; i < 10; i++) wo[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_tests++; if (class_out !== 4'd0) begin n_fail++; $display("FAIL reset_class: got %0d want 0", class_out); end
  endtask

  task automatic test_all_zero();
    int lat;
    set_prod_weights();
    h_in = '0;
    run_op(lat);
    n_tests++; if (lat !== 39) begin n_fail++; $display("FAIL zero_latency: got %0d want 39", lat); end
    n_tests++; if (class_out !== 4'd0) begin n_fail++; $display("FAIL zero_class: got %0d want 0", class_out); end
`ifdef OLM_SCORES_EN
    for (int i = 0; i < 10; i++) begin
      n_tests++; if (score(i) !== 0) begin n_fail++; $display("FAIL zero_score%0d: got %0d want 0", i, score(i)); end
    end
`endif
  endtask

  task automatic test_unit_act();
    int lat;
    set_prod_weights();
    h_in = '0; h_in[7:0] = 8'd1;
    run_op(lat);
    n_tests++; if (class_out !== 4'd8) begin n_fail++; $display("FAIL unit_class: got %0d want 8", class_out); end
`ifdef OLM_SCORES_EN
    for (int i = 0; i < 10; i++) begin
      n_tests++; if (score(i) !== pw[i]) begin n_fail++; $display("FAIL unit_score%0d: got %0d want %0d", i, score(i), pw[i]); end
    end
`endif
  endtask

  task automatic test_full_act();
    int lat;
    set_prod_weights();
    h_in = '0; h_in[7:0] = 8'd255;
    run_op(lat);
    n_tests++; if (class_out !== 4'd8) begin n_fail++; $display("FAIL full_class: got %0d want 8", class_out); end
`ifdef OLM_SCORES_EN
    n_tests++; if (score(8) !== 7650) begin n_fail++; $display("FAIL full_score8: got %0d want 7650", score(8)); end
    n_tests++; if (score(2) !== -7650) begin n_fail++; $display("FAIL full_score2: got %0d want -7650", score(2)); end
`endif
  endtask

  task automatic test_neg_zero();
    int lat;
    for (int i = 0; i < 10; i++) wo[i] = '0;
    for (int i = 0; i < 10; i++) wo[i][7:0] = (i == 4) ? 8'h80 : 8'h81;
    h_in = '0; h_in[7:0] = 8'd255;
    run_op(lat);
    n_tests++; if (class_out !== 4'd4) begin n_fail++; $display("FAIL negzero_class: got %0d want 4", class_out); end
`ifdef OLM_SCORES_EN
    n_tests++; if (score(4) !== 0) begin n_fail++; $display("FAIL negzero_score4: got %0d want 0", score(4)); end
    n_tests++; if (score(0) !== -255) begin n_fail++; $display("FAIL negzero_score0: got %0d want -255", score(0)); end
`endif
  endtask

  task automatic test_max_range();
    int lat;
    for (int i = 0; i < 10; i++)
      for (int k = 0; k < 30; k++) wo[i][8*k +: 8] = (i == 5) ? 8'h7F : 8'hFF;
    h_in = '1;
    run_op(lat);
    n_tests++; if (class_out !== 4'd5) begin n_fail++; $display("FAIL max_class: got %0d want 5", class_out); end
`ifdef OLM_SCORES_EN
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if (score(i) !== ((i == 5) ? 971550 : -971550)) begin
        n_fail++; $display("FAIL max_score%0d: got %0d want %0d", i, score(i), (i == 5) ? 971550 : -971550);
      end
    end
`endif
  endtask

  task automatic test_multi_byte();
    int lat;
    for (int i = 0; i < 10; i++) wo[i] = '0;
    h_in = '0; h_in[7:0] = 8'd2; h_in[239:232] = 8'd3;
    wo[1][7:0] = to_sm(10); wo[1][239:232] = to_sm(5);
    wo[9][239:232] = to_sm(12);
    run_op(lat);
    n_tests++; if (class_out !== 4'd9) begin n_fail++; $display("FAIL multi_class: got %0d want 9", class_out); end
`ifdef OLM_SCORES_EN
    n_tests++; if (score(1) !== 35) begin n_fail++; $display("FAIL multi_score1: got %0d want 35", score(1)); end
    n_tests++; if (score(9) !== 36) begin n_fail++; $display("FAIL multi_score9: got %0d want 36", score(9)); end
`endif
  endtask

  task automatic test_tie();
    int lat;
    for (int i = 0; i < 10; i++) wo[i] = '0;
    wo[3][7:0] = to_sm(5); wo[6][7:0] = to_sm(5);
    h_in = '0; h_in[7:0] = 8'd1;
    run_op(lat);
    n_tests++; if (class_out !== 4'd3) begin n_fail++; $display("FAIL tie_class: got %0d want 3", class_out); end
  endtask

  task automatic test_ignore_start();
    int lat;
    bit extra;
    set_prod_weights();
    h_in = '0; h_in[7:0] = 8'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    h_in = '0;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 10) start = 1'b1;
      if (lat == 11) start = 1'b0;
    end
    n_tests++; if (lat !== 39) begin n_fail++; $display("FAIL ignore_latency: got %0d want 39", lat); end
    n_tests++; if (class_out !== 4'd8) begin n_fail++; $display("FAIL ignore_class: got %0d want 8", class_out); end
    extra = 1'b0;
    repeat (45) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) extra = 1'b1;
    end
    n_tests++; if (extra !== 1'b0) begin n_fail++; $display("FAIL ignore_queued: got %b want 0", extra); end
  endtask

  task automatic test_back_to_back();
    int n;
    set_prod_weights();
    h_in = '0; h_in[7:0] = 8'd1;
    start = 1'b1;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (done !== 1'b1 && n < 100);
    start = 1'b0;
    n_tests++; if (n !== 40) begin n_fail++; $display("FAIL b2b_period: got %0d want 40", n); end
    n_tests++; if (class_out !== 4'd8) begin n_fail++; $display("FAIL b2b_class: got %0d want 8", class_out); end
    @(posedge clk); #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit seen;
    for (int i = 0; i < 10; i++)
      for (int k = 0; k < 30; k++) wo[i][8*k +: 8] = (i == 5) ? 8'h7F : 8'hFF;
    h_in = '1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    n_tests++; if (class_out !== 4'd0) begin n_fail++; $display("FAIL rstmid_class: got %0d want 0", class_out); end
    seen = 1'b0;
    repeat (50) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1'b1;
    end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b want 0", seen); end
    set_prod_weights();
    h_in = '0; h_in[7:0] = 8'd1;
    run_op(lat);
    n_tests++; if (lat !== 39) begin n_fail++; $display("FAIL rstmid_relatency: got %0d want 39", lat); end
    n_tests++; if (class_out !== 4'd8) begin n_fail++; $display("FAIL rstmid_reclass: got %0d want 8", class_out); end
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_unit_act();
    test_full_act();
    test_neg_zero();
    test_max_range();
    test_multi_byte();
    test_tie();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/output_layer_mac.md
Name: output_layer_mac

Overview:
Output-layer compute stage of the FNN, directly downstream of the output-weight ROM (ten 240-bit buses, one per output neuron). Consumes 30 hidden-layer activations and the ten weight buses. Computes ten dot products serially over the hidden index, with ten parallel accumulators, then runs a sequential argmax. Produces the 4-bit classified digit with a start/done handshake.

Parameters:
DATA_W, 8, width of one activation and one weight byte
N_HID, 30, hidden neurons (weight bytes per output bus)
N_OUT, 10, output neurons / classes
ACC_W, 24, signed accumulator width (must be >= 21)

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  synchronous active-high reset
start  in  1  request; accepted only when busy=0
h_in  in  240  hidden activations, unsigned; activation k = h_in[8k+7:8k]
wo0..wo9  in  240 each  weight buses; weight k of neuron i = woi[8k+7:8k], sign-magnitude (bit7 = sign, bits6:0 = magnitude)
busy  out  1  high from accept until done
done  out  1  one-cycle pulse; class_out valid
class_out  out  4  argmax index 0..9, held until next done

Behaviour:
- Reset (sync, active-high): state IDLE; busy=0, done=0, class_out=0; accumulators, k, j and best cleared. Reset mid-operation aborts the computation with no done.
- FSM states: IDLE, ACCUM, ARGMAX.
- IDLE: on start=1 (edge N), latch h_in into an internal register, clear all ten accumulators, set k=0, busy<=1, go to ACCUM. h_in may change after edge N without effect.
- ACCUM, edges N+1..N+30: acc_i += sm_mul(wo_i[k], h_reg[k]) for all i in parallel; k++. At k=29, go to ARGMAX with best=0, j=1.
- sm_mul: product = magnitude(7b) x activation(8b) = 15b unsigned, sign-extended to ACC_W and negated if sign=1. 8'h80 (negative zero) contributes 0.
- ARGMAX, edges N+31..N+39: if acc_j > acc_best (signed), best<=j; j++. The comparison is strict, so ties resolve to the lowest index.
- On edge N+39: class_out<=final best, done<=1, busy<=0, state IDLE. done deasserts on the next edge.
- Latency: start sampled at edge N -> done high in the cycle after edge N+39 (39 cycles).
- start while busy=1: ignored, not queued. start high in the same cycle as done: accepted, so back-to-back throughput is one result per 40 cycles.
- Maximum |acc| is 127*255*30 = 971550, so ACC_W=24 cannot overflow. No saturation logic.

Optional Feature:
Macro OLM_SCORES_EN.
- Defined: adds output port scores_out (N_OUT*ACC_W = 240 bits; score i at [24i+23:24i]). It is the registered accumulator values, updated together with done and held until the next done. Reset value 0.
- Undefined: port absent; accumulators remain internal only. class_out behaviour is identical in both cases.

Decomposition:
- Package olm_pkg: DATA_W, N_HID, N_OUT, ACC_W constants; FSM state enum; index width localparams (k 5b, j/best 4b).
- One sub-module, sm_mul, instantiated N_OUT times: sign-magnitude weight x unsigned activation -> signed ACC_W product. Purely combinational.

Test Plan:
- All activations 0, start -> done after 39 cycles, class_out=0 (all-tie, lowest index wins); with OLM_SCORES_EN, all scores 0.
- h_in byte0=1, others 0, production weights -> scores {-25,-4,-30,11,-2,-6,-19,0,30,3}, class_out=8.
- h_in byte0=255, others 0 -> score8=7650, score2=-7650, class_out=8; weight 8'h80 on any neuron contributes 0.
- All 30 activations 255, all weights forced to 8'h7F on neuron 5 and 8'hFF on others -> score5=971550, others -971550, class_out=5, no overflow.
- start held high continuously -> done every 40 cycles; mid-run pulses of start ignored; changing h_in after accept leaves result unchanged.
- rst asserted at cycle 15 of ACCUM -> next edge busy=0, done never pulses, class_out=0; a fresh start then yields the correct result.
